alu_issue_queue: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_issue_fifo.sv | 56 +++++
 rtl/alu_issue_queue.sv | 152 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared between the ALU and its issue queue.
//   opcode_t      - ALU operation encoding (ADD / MULT)
//   ALU_ADD_LAT   - cycles from op_valid to data_valid for ADD
//   ALU_MULT_LAT  - cycles from op_valid to data_valid for MULT
//   op_latency()  - result latency of a given opcode
package alu_pkg;

    typedef enum logic {
        OP_ADD  = 1'b0,
        OP_MULT = 1'b1
    } opcode_t;

    localparam int ALU_ADD_LAT  = 1;
    localparam int ALU_MULT_LAT = 3;

    function automatic int op_latency(opcode_t op);
        return (op == OP_MULT) ? ALU_MULT_LAT : ALU_ADD_LAT;
    endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: generic synchronous FIFO with asynchronous active-low reset.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   push, wdata   - write request and data (ignored while full)
//   pop           - remove head entry (ignored while empty)
//   rdata         - current head entry
//   full, empty   - occupancy flags
//   level         - number of stored entries (0..DEPTH)
module alu_issue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue without touching storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are only meaningful behind valid pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU requests and issues at most one per cycle,
// reserving the cycle each result will emerge so no two results collide.
// Ports:
//   clk, rst                   - clock, asynchronous active-low reset
//   a_i, b_i, opcode_i         - request operands and operation
//   valid_i / ready_o          - ingress handshake
//   tag_o                      - tag given to the request accepted this cycle
//   a_operand_o, b_operand_o,
//   opcode_o, op_valid_o       - issue port to the ALU
//   cmp_valid_o, cmp_tag_o     - completion, aligned with ALU data_valid
//   level_o                    - queue occupancy
// Optional build macro ALU_ISSUE_IN_ORDER_EN: results complete strictly in
// issue order (an op also waits for every longer-outstanding result).
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int DIN_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int ADD_LAT    = ALU_ADD_LAT,
    parameter int MULT_LAT   = ALU_MULT_LAT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIN_W-1:0]              a_i,
    input  logic [DIN_W-1:0]              b_i,
    input  opcode_t                       opcode_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [TAG_W-1:0]              tag_o,
    output logic [DIN_W-1:0]              a_operand_o,
    output logic [DIN_W-1:0]              b_operand_o,
    output opcode_t                       opcode_o,
    output logic                          op_valid_o,
    output logic                          cmp_valid_o,
    output logic [TAG_W-1:0]              cmp_tag_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int OP_W  = $bits(opcode_t);
    localparam int REQ_W = 2*DIN_W + OP_W + TAG_W;

    // Slot k of the scoreboard is the result emerging k cycles from now
    localparam logic [MULT_LAT:1] SLOT_ONE  = {{(MULT_LAT-1){1'b0}}, 1'b1};
    localparam logic [MULT_LAT:1] ADD_MASK  = SLOT_ONE << (ADD_LAT-1);
    localparam logic [MULT_LAT:1] MULT_MASK = SLOT_ONE << (MULT_LAT-1);

    logic [TAG_W-1:0]    tag_cnt;
    logic [REQ_W-1:0]    push_data;
    logic [REQ_W-1:0]    head_data;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                issue;

    logic [DIN_W-1:0]    head_a;
    logic [DIN_W-1:0]    head_b;
    opcode_t             head_op;
    logic [TAG_W-1:0]    head_tag;

    logic [MULT_LAT:1]   busy;
    logic [MULT_LAT:1]   busy_sh;
    logic [MULT_LAT:1]   lat_mask;
    logic [TAG_W-1:0]    slot_tag [1:MULT_LAT];
    logic                slot_free;
    logic                order_ok;

    assign ready_o   = !fifo_full;
    assign push      = valid_i && ready_o;
    assign tag_o     = tag_cnt;
    assign push_data = {a_i, b_i, opcode_i, tag_cnt};

    assign head_a   = head_data[REQ_W-1 -: DIN_W];
    assign head_b   = head_data[REQ_W-1-DIN_W -: DIN_W];
    assign head_op  = opcode_t'(head_data[TAG_W +: OP_W]);
    assign head_tag = head_data[TAG_W-1:0];

    alu_issue_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .wdata (push_data),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    // Issue decision looks at the scoreboard as it will be after this
    // cycle's shift, so a slot freed this cycle can be reused immediately
    assign busy_sh   = {1'b0, busy[MULT_LAT:2]};
    assign lat_mask  = (head_op == OP_MULT) ? MULT_MASK : ADD_MASK;
    assign slot_free = ~|(busy_sh & lat_mask);

`ifdef ALU_ISSUE_IN_ORDER_EN
    // Any pending result further out than ours would complete after it
    assign order_ok = ~|(busy_sh & ~(lat_mask | (lat_mask - SLOT_ONE)));
`else
    assign order_ok = 1'b1;
`endif

    assign issue = !fifo_empty && slot_free && order_ok;

    // Tag counter advances once per accepted request and wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_cnt <= '0;
        end else if (push) begin
            tag_cnt <= tag_cnt + 1'b1;
        end
    end

    // Scoreboard shift plus reservation; slot 1 leaving drives completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            cmp_valid_o <= 1'b0;
            cmp_tag_o   <= '0;
            for (int k = 1; k <= MULT_LAT; k++) slot_tag[k] <= '0;
        end else begin
            cmp_valid_o <= busy[1];
            cmp_tag_o   <= slot_tag[1];
            busy        <= busy_sh | (issue ? lat_mask : '0);
            for (int k = 1; k < MULT_LAT; k++) begin
                slot_tag[k] <= (issue && lat_mask[k]) ? head_tag : slot_tag[k+1];
            end
            slot_tag[MULT_LAT] <= (issue && lat_mask[MULT_LAT]) ? head_tag : '0;
        end
    end

    // ALU issue port; operands hold their last value between issues
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_valid_o  <= 1'b0;
            a_operand_o <= '0;
            b_operand_o <= '0;
            opcode_o    <= OP_ADD;
        end else begin
            op_valid_o <= issue;
            if (issue) begin
                a_operand_o <= head_a;
                b_operand_o <= head_b;
                opcode_o    <= head_op;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scoreboard bench for alu_issue_queue.
// A reference model reserves completion cycles from the latency rules and
// queues expected issues/completions; a negedge monitor compares them.
// Honours ALU_ISSUE_IN_ORDER_EN when the bench is built with it.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int DIN_W      = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;
    localparam int ADD_LAT    = 1;
    localparam int MULT_LAT   = 3;

    logic               clk;
    logic               rst;
    logic [DIN_W-1:0]   a_i;
    logic [DIN_W-1:0]   b_i;
    opcode_t            opcode_i;
    logic               valid_i;
    logic               ready_o;
    logic [TAG_W-1:0]   tag_o;
    logic [DIN_W-1:0]   a_operand_o;
    logic [DIN_W-1:0]   b_operand_o;
    opcode_t            opcode_o;
    logic               op_valid_o;
    logic               cmp_valid_o;
    logic [TAG_W-1:0]   cmp_tag_o;
    logic [2:0]         level_o;

    alu_issue_queue #(
        .DIN_W      (DIN_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TAG_W      (TAG_W),
        .ADD_LAT    (ADD_LAT),
        .MULT_LAT   (MULT_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_i         (a_i),
        .b_i         (b_i),
        .opcode_i    (opcode_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .tag_o       (tag_o),
        .a_operand_o (a_operand_o),
        .b_operand_o (b_operand_o),
        .opcode_o    (opcode_o),
        .op_valid_o  (op_valid_o),
        .cmp_valid_o (cmp_valid_o),
        .cmp_tag_o   (cmp_tag_o),
        .level_o     (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DIN_W-1:0] a;
        logic [DIN_W-1:0] b;
        opcode_t          op;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct {
        int               cyc;
        logic [DIN_W-1:0] a;
        logic [DIN_W-1:0] b;
        opcode_t          op;
    } iss_t;

    typedef struct {
        int               cyc;
        logic [TAG_W-1:0] tag;
    } cmp_t;

    req_t mq[$];
    int   resv[$];
    iss_t exp_iss[$];
    cmp_t exp_cmp[$];
    logic [TAG_W-1:0] m_tag;
    int   cyc;

    int   n_checks;
    int   n_errors;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)",
                     name, actual, expected, cyc, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DIN_W-1:0] a,
                                 input logic [DIN_W-1:0] b, input opcode_t op);
        @(negedge clk);
        valid_i  = v;
        a_i      = a;
        b_i      = b;
        opcode_i = op;
    endtask

    // Reference model: one step per clock edge, written in terms of
    // "which future cycle is each result reserved for"
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            resv.delete();
            exp_iss.delete();
            exp_cmp.delete();
            m_tag = '0;
            cyc   = 0;
        end else begin
            int   sz0;
            int   done;
            int   pos;
            bit   ok;
            req_t r;
            cyc++;
            sz0 = mq.size();
            for (int i = resv.size() - 1; i >= 0; i--)
                if (resv[i] <= cyc) resv.delete(i);
            if (sz0 > 0) begin
                done = cyc + ((mq[0].op == OP_MULT) ? MULT_LAT : ADD_LAT);
                ok = 1'b1;
                foreach (resv[i]) if (resv[i] == done) ok = 1'b0;
`ifdef ALU_ISSUE_IN_ORDER_EN
                foreach (resv[i]) if (resv[i] > done) ok = 1'b0;
`endif
                if (ok) begin
                    r = mq.pop_front();
                    exp_iss.push_back('{cyc, r.a, r.b, r.op});
                    pos = exp_cmp.size();
                    for (int i = 0; i < exp_cmp.size(); i++) begin
                        if (exp_cmp[i].cyc > done) begin
                            pos = i;
                            break;
                        end
                    end
                    exp_cmp.insert(pos, '{done, r.tag});
                    resv.push_back(done);
                end
            end
            if (valid_i && sz0 < FIFO_DEPTH) begin
                mq.push_back('{a_i, b_i, opcode_i, m_tag});
                m_tag = m_tag + 1'b1;
            end
        end
    end

    // Monitor: compares status every cycle and pops expected issue and
    // completion events whenever the DUT presents them
    always @(negedge clk) begin
        iss_t ei;
        cmp_t ec;
        checkOutput("level_o", 32'(level_o), 32'(mq.size()));
        checkOutput("ready_o", 32'(ready_o), 32'(mq.size() < FIFO_DEPTH));
        checkOutput("tag_o", 32'(tag_o), 32'(m_tag));
        if (op_valid_o) begin
            if (exp_iss.size() == 0) begin
                checkOutput("unexpected_issue", 32'(op_valid_o), 32'd0);
            end else begin
                ei = exp_iss.pop_front();
                checkOutput("issue_cycle", 32'(cyc), 32'(ei.cyc));
                checkOutput("a_operand_o", 32'(a_operand_o), 32'(ei.a));
                checkOutput("b_operand_o", 32'(b_operand_o), 32'(ei.b));
                checkOutput("opcode_o", 32'(opcode_o), 32'(ei.op));
            end
        end else if (exp_iss.size() > 0 && exp_iss[0].cyc <= cyc) begin
            ei = exp_iss.pop_front();
            checkOutput("missing_issue", 32'(op_valid_o), 32'd1);
        end
        if (cmp_valid_o) begin
            if (exp_cmp.size() == 0) begin
                checkOutput("unexpected_cmp", 32'(cmp_valid_o), 32'd0);
            end else begin
                ec = exp_cmp.pop_front();
                checkOutput("cmp_cycle", 32'(cyc), 32'(ec.cyc));
                checkOutput("cmp_tag_o", 32'(cmp_tag_o), 32'(ec.tag));
            end
        end else if (exp_cmp.size() > 0 && exp_cmp[0].cyc <= cyc) begin
            ec = exp_cmp.pop_front();
            checkOutput("missing_cmp", 32'(cmp_valid_o), 32'd1);
        end
    end

    task automatic checkResetOutputs(input string tagname);
        checkOutput({tagname, "_ready"},    32'(ready_o),     32'd1);
        checkOutput({tagname, "_level"},    32'(level_o),     32'd0);
        checkOutput({tagname, "_tag"},      32'(tag_o),       32'd0);
        checkOutput({tagname, "_op_valid"}, 32'(op_valid_o),  32'd0);
        checkOutput({tagname, "_cmp_valid"},32'(cmp_valid_o), 32'd0);
        checkOutput({tagname, "_cmp_tag"},  32'(cmp_tag_o),   32'd0);
        checkOutput({tagname, "_a_op"},     32'(a_operand_o), 32'd0);
        checkOutput({tagname, "_b_op"},     32'(b_operand_o), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        valid_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        opcode_i = OP_ADD;
        repeat (3) @(negedge clk);
        #1 checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // single ADD 3+4
        applyStimulus(1'b1, 8'd3, 8'd4, OP_ADD);
        repeat (4) applyStimulus(1'b0, 8'd0, 8'd0, OP_ADD);

        // MULT then ADD back to back: ADD completes first
        applyStimulus(1'b1, 8'd5, 8'd6, OP_MULT);
        applyStimulus(1'b1, 8'd7, 8'd8, OP_ADD);
        repeat (5) applyStimulus(1'b0, 8'd0, 8'd0, OP_ADD);

        // MULT, gap, ADD: ADD would land on the MULT's completion slot
        applyStimulus(1'b1, 8'd9, 8'd10, OP_MULT);
        applyStimulus(1'b0, 8'd0, 8'd0, OP_ADD);
        applyStimulus(1'b1, 8'd11, 8'd12, OP_ADD);
        repeat (6) applyStimulus(1'b0, 8'd0, 8'd0, OP_ADD);

        // M,M,A pattern stalls issue and fills the queue
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 8'(i), 8'(i + 1), (i % 3 == 2) ? OP_ADD : OP_MULT);
        repeat (12) applyStimulus(1'b0, 8'd0, 8'd0, OP_ADD);

        // continuous random stream, tags wrap
        for (int i = 0; i < 40; i++)
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), opcode_t'($urandom_range(0, 1)));

        // asynchronous reset in the middle of traffic
        #2 rst = 1'b0;
        #1 checkResetOutputs("midreset");
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (6) applyStimulus(1'b0, 8'd0, 8'd0, OP_ADD);

        // random traffic with idle gaps
        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 9) < 8), 8'($urandom), 8'($urandom),
                          opcode_t'($urandom_range(0, 1)));

        // drain within a fixed cycle budget
        repeat (15) applyStimulus(1'b0, 8'd0, 8'd0, OP_ADD);
        checkOutput("drain_issue_q", 32'(exp_iss.size()), 32'd0);
        checkOutput("drain_cmp_q", 32'(exp_cmp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
